// File: rtl/nanov_spi_ram.sv
// nanov_spi_ram: SPI mode-0 target in front of a 2^ADDR_BITS byte RAM.
// All SPI pins are oversampled on clk12MHz through 2-flop synchronisers.
// Transaction: 8-bit opcode, 24-bit address (low ADDR_BITS kept), then data.
// Build option: define NANOV_SPI_RAM_WRITE_EN to accept the write opcode;
// without it the RAM is read-only and the write opcode is ignored.
module nanov_spi_ram #(
  parameter int unsigned ADDR_BITS = 10,
  parameter logic [7:0]  OP_READ   = 8'h03,
  parameter logic [7:0]  OP_WRITE  = 8'h02
) (
  input  logic clk12MHz,
  input  logic rstn,
  input  logic spi_clk,
  input  logic spi_select,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic spi_miso_oe,
  output logic busy
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

`ifdef NANOV_SPI_RAM_WRITE_EN
  localparam bit WRITE_EN = 1'b1;
`else
  localparam bit WRITE_EN = 1'b0;
`endif

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_ADDR   = 3'd2;
  localparam logic [2:0] S_READ   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_IGNORE = 3'd5;

  // Synchronisers plus one history stage each for clock and select edges.
  logic sclk_meta_q, sclk_meta_d, sclk_sync_q, sclk_sync_d, sclk_prev_q, sclk_prev_d;
  logic sel_meta_q, sel_meta_d, sel_sync_q, sel_sync_d, sel_prev_q, sel_prev_d;
  logic mosi_meta_q, mosi_meta_d, mosi_sync_q, mosi_sync_d;

  logic [2:0]           state_q, state_d;
  logic [4:0]           bit_cnt_q, bit_cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 is_read_q, is_read_d;
  logic [7:0]           tx_q, tx_d;
  logic                 load_q, load_d;
  logic                 miso_q, miso_d;
  logic                 oe_q, oe_d;
  logic [1:0]           settle_q, settle_d;
  logic                 armed_q, armed_d;

  logic       sclk_rise, sclk_fall, sel_rise, sel_fall;
  logic [7:0] shift_in;
  logic       wr_fire;

  logic [7:0] mem [DEPTH];

  assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
  assign sclk_fall = ~sclk_sync_q & sclk_prev_q;
  assign sel_rise  = sel_sync_q & ~sel_prev_q;
  assign sel_fall  = ~sel_sync_q & sel_prev_q;
  assign shift_in  = {shift_q[6:0], mosi_sync_q};

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign busy        = ~sel_sync_q;

  // Synchroniser next-state: each stage copies the one before it.
  always_comb begin
    sclk_meta_d = spi_clk;
    sclk_sync_d = sclk_meta_q;
    sclk_prev_d = sclk_sync_q;
    sel_meta_d  = spi_select;
    sel_sync_d  = sel_meta_q;
    sel_prev_d  = sel_sync_q;
    mosi_meta_d = spi_mosi;
    mosi_sync_d = mosi_meta_q;
  end

  // Protocol FSM: command, address, then streaming read or write bytes.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latches).
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    is_read_d = is_read_q;
    tx_d      = tx_q;
    load_d    = 1'b0;
    miso_d    = miso_q;
    wr_fire   = 1'b0;
    // A select edge is trusted only once the synchroniser has flushed after
    // reset and select has been seen high; a select held low across reset
    // must not open a transaction.
    settle_d  = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
    armed_d   = armed_q | ((settle_q == 2'd3) & sel_sync_q);

    if (sel_rise) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sel_fall && armed_q) begin
            state_d   = S_CMD;
            bit_cnt_d = 5'd0;
          end
        end
        S_CMD: begin
          if (sclk_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = 5'd0;
              if (shift_in == OP_READ) begin
                is_read_d = 1'b1;
                state_d   = S_ADDR;
              end else if (WRITE_EN && (shift_in == OP_WRITE)) begin
                is_read_d = 1'b0;
                state_d   = S_ADDR;
              end else begin
                state_d   = S_IGNORE;
              end
            end
          end
        end
        S_ADDR: begin
          if (sclk_rise) begin
            // Shifting all 24 bits through an ADDR_BITS register keeps the low bits.
            addr_d    = {addr_q[ADDR_BITS-2:0], mosi_sync_q};
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_d = 5'd0;
              if (is_read_q) begin
                state_d = S_READ;
                load_d  = 1'b1;
              end else begin
                state_d = S_WRITE;
              end
            end
          end
        end
        S_READ: begin
          if (load_q) begin
            tx_d = mem[addr_q];
          end else if (sclk_fall) begin
            miso_d    = tx_q[7];
            tx_d      = {tx_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              // Refill well before the next falling edge so bytes run back to back.
              bit_cnt_d = 5'd0;
              addr_d    = addr_q + ADDR_BITS'(1);
              load_d    = 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (sclk_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = 5'd0;
              wr_fire   = WRITE_EN;
              addr_d    = addr_q + ADDR_BITS'(1);
            end
          end
        end
        S_IGNORE: begin
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (state_d != S_READ) miso_d = 1'b0;
    oe_d = (state_d == S_READ);
  end

  // Control and synchroniser registers.
  always_ff @(posedge clk12MHz or negedge rstn) begin
    if (!rstn) begin
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;
      sel_meta_q  <= 1'b1;
      sel_sync_q  <= 1'b1;
      sel_prev_q  <= 1'b1;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      state_q     <= S_IDLE;
      bit_cnt_q   <= 5'd0;
      shift_q     <= 8'd0;
      addr_q      <= '0;
      is_read_q   <= 1'b1;
      tx_q        <= 8'd0;
      load_q      <= 1'b0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      settle_q    <= 2'd0;
      armed_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sclk_meta_q <= sclk_meta_d;
      sclk_sync_q <= sclk_sync_d;
      sclk_prev_q <= sclk_prev_d;
      sel_meta_q  <= sel_meta_d;
      sel_sync_q  <= sel_sync_d;
      sel_prev_q  <= sel_prev_d;
      mosi_meta_q <= mosi_meta_d;
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      is_read_q   <= is_read_d;
      tx_q        <= tx_d;
      load_q      <= load_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      settle_q    <= settle_d;
      armed_q     <= armed_d;
    end
  end

  // Byte write port; the enable is constant zero in the read-only build.
  always_ff @(posedge clk12MHz) begin
    // NOTE: the array has no reset, so it stays a plain RAM and keeps its data across rstn.
    if (wr_fire) mem[addr_q] <= shift_in;
  end

endmodule

// File: tb/tb_nanov_spi_ram.sv
// Testbench for nanov_spi_ram: directed table, hand-written corner sequences
// and random transactions against a byte-array model of the RAM.
// Honours NANOV_SPI_RAM_WRITE_EN the same way as the design.
module tb_nanov_spi_ram;

  localparam int ADDR_BITS = 10;
  localparam int DEPTH     = 1 << ADDR_BITS;
  localparam int HALF      = 6;

`ifdef NANOV_SPI_RAM_WRITE_EN
  localparam bit WR = 1'b1;
`else
  localparam bit WR = 1'b0;
`endif

  typedef logic [7:0][7:0] bytes_t;

  typedef struct {
    logic [7:0]  op;
    logic [23:0] addr;
    int          n;
    bytes_t      tx;
    bytes_t      exp;
  } vec_t;

  logic clk12MHz = 1'b0;
  logic rstn = 1'b1;
  logic spi_clk = 1'b0;
  logic spi_select = 1'b1;
  logic spi_mosi = 1'b0;
  logic spi_miso, spi_miso_oe, busy;

  int n_vec = 0;
  int n_fail = 0;
  logic [7:0] model_mem [DEPTH];
  vec_t tbl [11];

  nanov_spi_ram #(.ADDR_BITS(ADDR_BITS), .OP_READ(8'h03), .OP_WRITE(8'h02)) dut (
    .clk12MHz(clk12MHz), .rstn(rstn), .spi_clk(spi_clk), .spi_select(spi_select),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .busy(busy)
  );

  always #5 clk12MHz = ~clk12MHz;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pre(input int a);
    logic [9:0] x;
    x = 10'(a);
    return x[7:0] ^ 8'h5A ^ {6'd0, x[9:8]};
  endfunction

  function automatic bytes_t b4(input logic [7:0] a0, input logic [7:0] a1,
                                input logic [7:0] a2, input logic [7:0] a3);
    bytes_t t;
    t = '0;
    t[0] = a0; t[1] = a1; t[2] = a2; t[3] = a3;
    return t;
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk12MHz);
  endtask

  // Mode-0 initiator: drive MOSI while SCK low, sample MISO just before SCK rises.
  task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx,
                          output logic oe_all, output logic quiet_all);
    rx = '0; oe_all = 1'b1; quiet_all = 1'b1;
    for (int k = 0; k < nb; k++) begin
      spi_mosi = tx[7-k];
      wait_clks(HALF);
      rx[7-k]   = spi_miso;
      oe_all    = oe_all & spi_miso_oe;
      quiet_all = quiet_all & ~spi_miso_oe & ~spi_miso;
      spi_clk = 1'b1;
      wait_clks(HALF);
      spi_clk = 1'b0;
    end
  endtask

  task automatic spi_begin();
    spi_select = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic spi_end();
    wait_clks(HALF);
    spi_select = 1'b1;
    wait_clks(2 * HALF);
  endtask

  // Full transaction; quiet_all covers the header, plus the data for non-reads.
  task automatic xfer(input logic [7:0] op, input logic [23:0] addr, input int n, input bytes_t tx,
                      output bytes_t rx, output logic oe_all, output logic quiet_all);
    logic [7:0] r;
    logic o, q;
    rx = '0; oe_all = 1'b1; quiet_all = 1'b1;
    spi_begin();
    spi_bits(op, 8, r, o, q);
    quiet_all &= q;
    for (int j = 2; j >= 0; j--) begin
      spi_bits(addr[j*8 +: 8], 8, r, o, q);
      quiet_all &= q;
    end
    for (int i = 0; i < n; i++) begin
      spi_bits(tx[i], 8, r, o, q);
      rx[i] = r;
      oe_all &= o;
      if (op != 8'h03) quiet_all &= q;
    end
    spi_end();
  endtask

  task automatic model_write(input logic [7:0] op, input logic [23:0] addr, input int n, input bytes_t tx);
    int a;
    a = int'(addr) % DEPTH;
    if (WR && op == 8'h02)
      for (int i = 0; i < n; i++) model_mem[(a + i) % DEPTH] = tx[i];
  endtask

  // Transaction checked entirely against the model.
  task automatic run_txn(input string tag, input logic [7:0] op, input logic [23:0] addr,
                         input int n, input bytes_t tx);
    bytes_t rx, exp;
    logic oe_all, quiet_all;
    int a;
    a = int'(addr) % DEPTH;
    exp = '0;
    for (int i = 0; i < n; i++) exp[i] = model_mem[(a + i) % DEPTH];
    xfer(op, addr, n, tx, rx, oe_all, quiet_all);
    if (op == 8'h03) begin
      for (int i = 0; i < n; i++) check($sformatf("%s rd[%0d]", tag, i), rx[i], exp[i]);
      check($sformatf("%s oe", tag), oe_all, 1);
      check($sformatf("%s hdr quiet", tag), quiet_all, 1);
    end else begin
      check($sformatf("%s quiet", tag), quiet_all, 1);
      model_write(op, addr, n, tx);
    end
  endtask

  initial begin
    logic [7:0] r;
    logic o, q, q_all;
    bytes_t rx;
    logic oe_all, quiet_all;
    logic [7:0] op;
    logic [23:0] addr;
    bytes_t tx;
    int n;

    // Directed table; expected read data follows the build's write capability.
    tbl[0]  = '{8'h02, 24'h000010, 2, b4(8'hA5, 8'h3C, 0, 0), '0};
    tbl[1]  = '{8'h03, 24'h000010, 2, '0, b4(WR ? 8'hA5 : pre(16), WR ? 8'h3C : pre(17), 0, 0)};
    tbl[2]  = '{8'h02, 24'h0003FF, 2, b4(8'h11, 8'h22, 0, 0), '0};
    tbl[3]  = '{8'h03, 24'h000000, 1, '0, b4(WR ? 8'h22 : pre(0), 0, 0, 0)};
    tbl[4]  = '{8'h03, 24'h0003FF, 1, '0, b4(WR ? 8'h11 : pre(1023), 0, 0, 0)};
    tbl[5]  = '{8'h9F, 24'h000010, 1, b4(8'hFF, 0, 0, 0), '0};
    tbl[6]  = '{8'h03, 24'h000010, 1, '0, b4(WR ? 8'hA5 : pre(16), 0, 0, 0)};
    tbl[7]  = '{8'h03, 24'hFFFC10, 2, '0, b4(WR ? 8'hA5 : pre(16), WR ? 8'h3C : pre(17), 0, 0)};
    tbl[8]  = '{8'h02, 24'h000010, 1, b4(8'h77, 0, 0, 0), '0};
    tbl[9]  = '{8'h03, 24'h000010, 1, '0, b4(WR ? 8'h77 : pre(16), 0, 0, 0)};
    tbl[10] = '{8'h03, 24'h0003FE, 3, '0,
                b4(pre(1022), WR ? 8'h11 : pre(1023), WR ? 8'h22 : pre(0), 0)};

    // Memory is undefined after power-up: give design and model the same contents.
    for (int i = 0; i < DEPTH; i++) begin
      dut.mem[i]   = pre(i);
      model_mem[i] = pre(i);
    end

    #1 rstn = 1'b0;
    #2;
    check("reset miso", spi_miso, 0);
    check("reset oe", spi_miso_oe, 0);
    check("reset busy", busy, 0);
    wait_clks(5);
    rstn = 1'b1;
    wait_clks(10);

    // busy follows the synchronised select.
    spi_select = 1'b0;
    wait_clks(4);
    check("busy low select", busy, 1);
    spi_select = 1'b1;
    wait_clks(4);
    check("busy high select", busy, 0);
    wait_clks(4);

    for (int t = 0; t < 11; t++) begin
      xfer(tbl[t].op, tbl[t].addr, tbl[t].n, tbl[t].tx, rx, oe_all, quiet_all);
      if (tbl[t].op == 8'h03) begin
        for (int i = 0; i < tbl[t].n; i++)
          check($sformatf("tbl%0d rd[%0d]", t, i), rx[i], tbl[t].exp[i]);
        check($sformatf("tbl%0d oe", t), oe_all, 1);
      end else begin
        check($sformatf("tbl%0d quiet", t), quiet_all, 1);
        model_write(tbl[t].op, tbl[t].addr, tbl[t].n, tbl[t].tx);
      end
    end

    // SCK toggling while deselected must do nothing.
    spi_bits(8'h03, 8, r, o, q_all);
    spi_bits(8'h00, 8, r, o, q);
    q_all &= q;
    spi_bits(8'h20, 8, r, o, q);
    q_all &= q;
    check("desel sck quiet", q_all, 1);
    run_txn("after desel", 8'h03, 24'h000020, 1, '0);

    // Partial write byte then deselect: no memory update.
    spi_begin();
    spi_bits(8'h02, 8, r, o, q);
    spi_bits(8'h00, 8, r, o, q);
    spi_bits(8'h00, 8, r, o, q);
    spi_bits(8'h20, 8, r, o, q);
    spi_bits(8'hFF, 5, r, o, q);
    spi_end();
    run_txn("partial wr", 8'h03, 24'h000020, 1, '0);

    // Reset while MISO is driving a 1 during a read.
    spi_begin();
    spi_bits(8'h03, 8, r, o, q);
    spi_bits(8'h00, 8, r, o, q);
    spi_bits(8'h00, 8, r, o, q);
    spi_bits(8'h80, 8, r, o, q);
    wait_clks(4);
    check("pre-reset miso", spi_miso, model_mem[8'h80][7]);
    check("pre-reset oe", spi_miso_oe, 1);
    #2 rstn = 1'b0;
    #1;
    check("mid-read rst miso", spi_miso, 0);
    check("mid-read rst oe", spi_miso_oe, 0);
    check("mid-read rst busy", busy, 0);
    wait_clks(3);
    rstn = 1'b1;
    wait_clks(10);
    // Select still low from before reset: a full read must be ignored.
    spi_bits(8'h03, 8, r, o, q_all);
    for (int j = 0; j < 4; j++) begin
      spi_bits(8'h10, 8, r, o, q);
      q_all &= q;
    end
    check("held select quiet", q_all, 1);
    spi_end();
    run_txn("post hold", 8'h03, 24'h000010, 1, '0);

    // Reset after 12 address bits, then a fresh read.
    spi_begin();
    spi_bits(8'h03, 8, r, o, q);
    spi_bits(8'h00, 8, r, o, q);
    spi_bits(8'h00, 4, r, o, q);
    #2 rstn = 1'b0;
    #1;
    check("addr rst miso", spi_miso, 0);
    check("addr rst oe", spi_miso_oe, 0);
    spi_select = 1'b1;
    wait_clks(3);
    rstn = 1'b1;
    wait_clks(10);
    run_txn("post addr rst", 8'h03, 24'h000010, 2, '0);

    // Random traffic against the model.
    for (int t = 0; t < 24; t++) begin
      case ($urandom_range(0, 4))
        0, 1:    op = 8'h03;
        2, 3:    op = 8'h02;
        default: begin
          do op = 8'($urandom); while (op == 8'h02 || op == 8'h03);
        end
      endcase
      addr = 24'($urandom);
      if ($urandom_range(0, 2) == 0) addr = addr | 24'h0003FD;
      n = int'($urandom_range(1, 4));
      tx = '0;
      for (int i = 0; i < n; i++) tx[i] = 8'($urandom);
      run_txn($sformatf("rnd%0d op%02h a%06h", t, op, addr), op, addr, n, tx);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/nanov_spi_ram.md
NANOV_SPI_RAM -- requirements
Module: nanov_spi_ram

Interface
REQ-001 Parameter ADDR_BITS, default 10, byte-address width of the internal memory (2^ADDR_BITS bytes).
REQ-002 Parameter OP_READ, default 8'h03, read command opcode.
REQ-003 Parameter OP_WRITE, default 8'h02, write command opcode.
REQ-004 clk12MHz  input  1  system clock; all logic on its rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 spi_clk  input  1  SPI clock from initiator, mode 0, asynchronous to clk12MHz.
REQ-007 spi_select  input  1  chip select, active-low.
REQ-008 spi_mosi  input  1  serial data in, MSB first.
REQ-009 spi_miso  output  1  serial data out, MSB first.
REQ-010 spi_miso_oe  output  1  high while read data is being driven; pad tristate control.
REQ-011 busy  output  1  high while spi_select is low (synchronised).

Function
REQ-012 spi_clk, spi_select, spi_mosi SHALL each pass a 2-flop synchroniser; edges SHALL be detected from the synchronised spi_clk.
REQ-013 Initiator timing: spi_clk high and low phases each >= 4 clk12MHz cycles; faster clocks are out of scope.
REQ-014 spi_mosi SHALL be sampled on synchronised spi_clk rising edges only; spi_miso SHALL change only on synchronised falling edges, within 2 clk12MHz cycles of edge detection.
REQ-015 States: IDLE, CMD, ADDR, READ, WRITE, IGNORE.
REQ-016 IDLE -> CMD on synchronised spi_select falling; bit counter cleared.
REQ-017 CMD: shift 8 bits; on 8th bit, opcode == OP_READ or OP_WRITE -> ADDR, else -> IGNORE.
REQ-018 ADDR: shift 24 bits; address = low ADDR_BITS bits, upper bits discarded; on 24th bit -> READ or WRITE per opcode.
REQ-019 READ: byte at address fetched in the cycle after the 24th address bit; its MSB SHALL appear on spi_miso at the next falling edge; each subsequent falling edge shifts the next bit.
REQ-020 READ: after 8 bits, address increments and next byte's MSB follows on the next falling edge, with no gap.
REQ-021 WRITE: after 8 bits sampled, byte SHALL be written to memory at address within 2 cycles, address increments.
REQ-022 Address increment SHALL wrap from 2^ADDR_BITS-1 to 0.
REQ-023 IGNORE: discard all bits; spi_miso_oe stays 0.
REQ-024 Synchronised spi_select rising in any state SHALL return to IDLE next cycle; partial write byte discarded, no memory write.
REQ-025 spi_clk edges while spi_select high SHALL be ignored.
REQ-026 spi_miso_oe = 1 only in READ; in all other states spi_miso = 0.
REQ-027 busy = inverse of synchronised spi_select.

Reset
REQ-028 rstn low SHALL immediately force state IDLE, counters 0, spi_miso 0, spi_miso_oe 0, busy 0, synchronisers to idle levels (select 1, clk 0, mosi 0).
REQ-029 Memory contents SHALL be unaffected by rstn; after power-up they are undefined.
REQ-030 rstn asserted mid-transaction SHALL abort it; deassertion with spi_select low SHALL remain in IDLE until the next spi_select falling edge.

Configuration
REQ-031 Macro NANOV_SPI_RAM_WRITE_EN defined: OP_WRITE supported per REQ-021.
REQ-032 Macro undefined: memory read-only, no write port synthesised; OP_WRITE treated as unknown opcode -> IGNORE.

Verification
REQ-033 Write 02 000010 A5 3C, select high; read 03 000010 + 16 clocks -> MISO A5 3C (macro defined).
REQ-034 Write 02 0003FF 11 22 with ADDR_BITS=10; read 03 000000 -> 22; read 03 0003FF -> 11.
REQ-035 Opcode 0x9F + 32 clocks -> spi_miso_oe 0 and spi_miso 0 throughout; memory unchanged.
REQ-036 Write 02 000020 + 5 bits of 0xFF then select high; read 03 000020 -> previous byte value unchanged.
REQ-037 rstn low after 12 address bits, release, new read 03 000010 -> correct data; spi_miso 0 during reset.
REQ-038 Macro undefined: write 02 000010 77 then read 03 000010 -> original (preloaded) value, not 77.
